// File: rtl/display_scan_pwm.sv
// Multiplexed display scanner: one digit per slot, blanking at the start of each slot,
// brightness PWM on the active-low enable. All outputs come straight from flops.
module display_scan_pwm #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SEG_W      = 8,
    parameter int unsigned DWELL      = 1000,
    parameter int unsigned BLANK      = 16,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       disp_enable,
    input  logic [BRIGHT_W-1:0]         brightness,
    input  logic                        scan_en,
    output logic [NUM_DIGITS-1:0]       Bus_En,
    output logic [SEG_W-1:0]            Bus_Segments,
    output logic                        frame_start
);

    localparam int unsigned CNT_W = $clog2(DWELL);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  running_q, running_d;
    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [SEG_W-1:0]      pat_q, pat_d;
    logic                  en_q, en_d;
    logic [BRIGHT_W-1:0]   bright_q, bright_d;
    logic [NUM_DIGITS-1:0] bus_en_q, bus_en_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  frame_q, frame_d;
    logic                  boundary;
    logic                  driving;
    logic [BRIGHT_W-1:0]   phase;

    // Next counter/latch state: a boundary is either the first enabled edge or a slot wrap.
    always_comb begin
        running_d   = running_q;
        slot_cnt_d  = slot_cnt_q;
        digit_idx_d = digit_idx_q;
        pat_d       = pat_q;
        en_d        = en_q;
        bright_d    = bright_q;
        boundary    = 1'b0;
        if (!scan_en) begin
            running_d   = 1'b0;
            slot_cnt_d  = '0;
            digit_idx_d = '0;
        end else if (!running_q) begin
            running_d   = 1'b1;
            slot_cnt_d  = '0;
            digit_idx_d = '0;
            boundary    = 1'b1;
        end else if (slot_cnt_q == CNT_W'(DWELL - 1)) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
            boundary    = 1'b1;
        end else begin
            slot_cnt_d  = slot_cnt_q + 1'b1;
        end
        if (boundary) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_idx_d == IDX_W'(i)) begin
                    pat_d = digits[i*SEG_W +: SEG_W];
                    en_d  = disp_enable[i];
                end
            end
            bright_d = brightness;
        end
    end

    // Outputs are computed from next state so the registered value belongs to the new cycle.
    always_comb begin
        phase    = BRIGHT_W'(32'(slot_cnt_d) - BLANK);
        driving  = running_d && ((32'(slot_cnt_d) + 32'd1) > BLANK) && en_d
                   && (phase <= bright_d);
        bus_en_d = '1;
        seg_d    = '0;
        if (driving) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_idx_d == IDX_W'(i)) begin
                    bus_en_d[i] = 1'b0;
                end
            end
            seg_d = pat_d;
        end
        frame_d = boundary && (digit_idx_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q   <= 1'b0;
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
            pat_q       <= '0;
            en_q        <= 1'b0;
            bright_q    <= '0;
            bus_en_q    <= '1;
            seg_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            running_q   <= running_d;
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            pat_q       <= pat_d;
            en_q        <= en_d;
            bright_q    <= bright_d;
            bus_en_q    <= bus_en_d;
            seg_q       <= seg_d;
            frame_q     <= frame_d;
        end
    end

    assign Bus_En       = bus_en_q;
    assign Bus_Segments = seg_q;
    assign frame_start  = frame_q;

endmodule

// File: tb/tb_display_scan_pwm.sv
// Bench for display_scan_pwm: directed vector table, corner sequences, and random stimulus
// checked every cycle against a time-based reference model.
module tb_display_scan_pwm;

    localparam int N  = 6;
    localparam int SW = 8;
    localparam int DW = 8;
    localparam int BL = 2;
    localparam int BW = 2;
    localparam logic [47:0] DIGS = 48'h06_05_04_03_02_01;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N*SW-1:0] digits = DIGS;
    logic [N-1:0]  disp_enable = '1;
    logic [BW-1:0] brightness = '1;
    logic          scan_en = 1'b1;
    logic [N-1:0]  Bus_En;
    logic [SW-1:0] Bus_Segments;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_pwm #(
        .NUM_DIGITS(N), .SEG_W(SW), .DWELL(DW), .BLANK(BL), .BRIGHT_W(BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .disp_enable (disp_enable),
        .brightness  (brightness),
        .scan_en     (scan_en),
        .Bus_En      (Bus_En),
        .Bus_Segments(Bus_Segments),
        .frame_start (frame_start)
    );

    // Reference model: global time since the scan (re)started, digit and cycle derived by arithmetic.
    bit            m_active;
    int            m_t;
    logic [SW-1:0] m_pat;
    logic          m_en;
    logic [BW-1:0] m_br;

    function automatic void model_reset();
        m_active = 0;
        m_t      = 0;
        m_pat    = '0;
        m_en     = 1'b0;
        m_br     = '0;
    endfunction

    task automatic model_edge();
        int i;
        if (!rst_n) begin
            model_reset();
        end else if (!scan_en) begin
            m_active = 0;
            m_t      = 0;
        end else begin
            if (!m_active) begin
                m_active = 1;
                m_t      = 0;
            end else begin
                m_t++;
            end
            if (m_t % DW == 0) begin
                i     = (m_t / DW) % N;
                m_pat = digits[i*SW +: SW];
                m_en  = disp_enable[i];
                m_br  = brightness;
            end
        end
    endtask

    task automatic model_expect(output logic [N-1:0] e_en, output logic [SW-1:0] e_seg,
                                output logic e_fs);
        int k;
        int idx;
        k     = m_t % DW;
        idx   = (m_t / DW) % N;
        e_en  = '1;
        e_seg = '0;
        e_fs  = m_active && (m_t % (N * DW) == 0);
        if (m_active && k >= BL && m_en && (((k - BL) % (1 << BW)) <= int'(m_br))) begin
            e_en[idx] = 1'b0;
            e_seg     = m_pat;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0]  e_en;
        logic [SW-1:0] e_seg;
        logic          e_fs;
        model_expect(e_en, e_seg, e_fs);
        check_val({tag, " Bus_En"}, 32'(Bus_En), 32'(e_en));
        check_val({tag, " Bus_Segments"}, 32'(Bus_Segments), 32'(e_seg));
        check_val({tag, " frame_start"}, 32'(frame_start), 32'(e_fs));
        check_val({tag, " one_enable"}, 32'($countones(~Bus_En) <= 1), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic expect_out(input string tag, input logic [N-1:0] en, input logic [SW-1:0] seg,
                              input logic fs);
        check_val({tag, " Bus_En"}, 32'(Bus_En), 32'(en));
        check_val({tag, " Bus_Segments"}, 32'(Bus_Segments), 32'(seg));
        check_val({tag, " frame_start"}, 32'(frame_start), 32'(fs));
    endtask

    // Called just after a falling edge; leaves the bench at the negedge of cycle 0.
    task automatic restart(input logic [N-1:0] en, input logic [BW-1:0] br);
        rst_n = 1'b0;
        model_reset();
        digits      = DIGS;
        disp_enable = en;
        brightness  = br;
        scan_en     = 1'b1;
        #1 rst_n = 1'b1;
        tick("start");
    endtask

    task automatic run_to(input int cyc, input int now);
        for (int c = now; c < cyc; c++) tick("run");
    endtask

    typedef struct {
        logic [N-1:0]  en;
        logic [BW-1:0] br;
        int            cyc;
        logic [N-1:0]  exp_en;
        logic [SW-1:0] exp_seg;
        logic          exp_fs;
    } vec_t;

    vec_t vecs[$];
    int   pause_left;

    initial begin
        vecs.push_back('{6'h3F, 2'd3,  0, 6'h3F, 8'h00, 1'b1});
        vecs.push_back('{6'h3F, 2'd3,  1, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3F, 2'd3,  2, 6'h3E, 8'h01, 1'b0});
        vecs.push_back('{6'h3F, 2'd3,  7, 6'h3E, 8'h01, 1'b0});
        vecs.push_back('{6'h3F, 2'd3,  8, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3F, 2'd3, 10, 6'h3D, 8'h02, 1'b0});
        vecs.push_back('{6'h3F, 2'd3, 47, 6'h1F, 8'h06, 1'b0});
        vecs.push_back('{6'h3F, 2'd3, 48, 6'h3F, 8'h00, 1'b1});
        vecs.push_back('{6'h3B, 2'd3, 18, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3B, 2'd3, 23, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3B, 2'd3, 26, 6'h37, 8'h04, 1'b0});
        vecs.push_back('{6'h3F, 2'd0,  2, 6'h3E, 8'h01, 1'b0});
        vecs.push_back('{6'h3F, 2'd0,  3, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3F, 2'd0,  6, 6'h3E, 8'h01, 1'b0});
        vecs.push_back('{6'h3F, 2'd0,  7, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3F, 2'd1,  3, 6'h3E, 8'h01, 1'b0});
        vecs.push_back('{6'h3F, 2'd1,  4, 6'h3F, 8'h00, 1'b0});
        vecs.push_back('{6'h3F, 2'd1,  7, 6'h3E, 8'h01, 1'b0});

        // Reset state
        #1 rst_n = 1'b0;
        model_reset();
        #1 expect_out("reset", 6'h3F, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset_hold");

        foreach (vecs[v]) begin
            restart(vecs[v].en, vecs[v].br);
            run_to(vecs[v].cyc, 0);
            expect_out($sformatf("vec%0d", v), vecs[v].exp_en, vecs[v].exp_seg, vecs[v].exp_fs);
        end

        // Reset mid-drive
        restart(6'h3F, 2'd3);
        run_to(4, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 expect_out("mid_reset", 6'h3F, 8'h00, 1'b0);
        #1 rst_n = 1'b1;
        tick("rel0");
        expect_out("rel_c0", 6'h3F, 8'h00, 1'b1);
        tick("rel1");
        expect_out("rel_c1", 6'h3F, 8'h00, 1'b0);
        tick("rel2");
        expect_out("rel_c2", 6'h3E, 8'h01, 1'b0);

        // Mid-slot change of digit3 and brightness
        restart(6'h3F, 2'd3);
        run_to(28, 0);
        digits[31:24] = 8'h7F;
        brightness    = 2'd0;
        for (int c = 29; c <= 31; c++) begin
            tick("mid");
            expect_out($sformatf("mid_c%0d", c), 6'h37, 8'h04, 1'b0);
        end
        run_to(74, 31);
        expect_out("next_c74", 6'h37, 8'h7F, 1'b0);
        tick("next");
        expect_out("next_c75", 6'h3F, 8'h00, 1'b0);
        run_to(78, 75);
        expect_out("next_c78", 6'h37, 8'h7F, 1'b0);

        // scan_en pause during slot 4
        restart(6'h3F, 2'd3);
        run_to(34, 0);
        scan_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick("pause");
            expect_out($sformatf("pause%0d", c), 6'h3F, 8'h00, 1'b0);
        end
        scan_en = 1'b1;
        tick("resume");
        expect_out("resume_c0", 6'h3F, 8'h00, 1'b1);
        tick("resume");
        expect_out("resume_c1", 6'h3F, 8'h00, 1'b0);
        tick("resume");
        expect_out("resume_c2", 6'h3E, 8'h01, 1'b0);

        // Randomised run against the model
        restart(6'h3F, 2'd3);
        pause_left = 0;
        for (int c = 0; c < 1500; c++) begin
            tick("rand");
            if ($urandom_range(5) == 0) digits = {$urandom, $urandom};
            if ($urandom_range(7) == 0) disp_enable = N'($urandom);
            if ($urandom_range(7) == 0) brightness = BW'($urandom);
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) scan_en = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                scan_en    = 1'b0;
                pause_left = int'($urandom_range(5, 1));
            end
            if ($urandom_range(299) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_outputs("rand_rst");
                #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
